lambda_peak_ctrl: RTL and testbench

- Sequencing controller for the lambda datapath, which computes lambda = mag - rho*phi with a fixed 5-cycle latency and carries no valid or handshake of its own.
- Accepts one window of WIN_LEN correlator samples (mag, phi) over a valid/ready handshake.
- Drives the datapath inputs and supplies it the rho latched at start.
- Tracks valid through the datapath latency, runs an argmax over the returned lambda values, and reports the peak index and value once per window (CP timing-offset decision).

---
 rtl/lambda_peak_ctrl.sv | 135 +++++++++++++
 tb/tb_lambda_peak_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lambda_peak_ctrl.sv
// Windowed argmax sequencer for the lambda datapath; peak reported DP_LAT+1 cycles after the last accept.
// in_ready is high only while collecting a window; the datapath itself is never stalled.
module lambda_peak_ctrl #(
   parameter int WIN_LEN = 256,
   parameter int DP_LAT  = 5,
   parameter int IDX_W   = $clog2(WIN_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       rho_cfg,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [13:0]      in_mag,
   input  logic [13:0]      in_phi,
   output logic [13:0]      dp_mag,
   output logic [13:0]      dp_phi,
   output logic [7:0]       dp_rho,
   input  logic [13:0]      dp_lambda,
   output logic             busy,
   output logic             peak_valid,
   output logic [IDX_W-1:0] peak_idx,
   output logic [13:0]      peak_val
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);
   localparam logic signed [13:0] MIN_VAL = 14'sh2000;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        in_cnt_q, in_cnt_d;
   logic [IDX_W-1:0]        out_cnt_q, out_cnt_d;
   logic [IDX_W-1:0]        max_idx_q, max_idx_d;
   logic [IDX_W-1:0]        peak_idx_q, peak_idx_d;
   logic signed [13:0]      max_val_q, max_val_d;
   logic signed [13:0]      peak_val_q, peak_val_d;
   logic [7:0]              rho_q, rho_d;
   logic [DP_LAT-1:0]       vpipe_q, vpipe_d;
   logic                    accept;
   logic                    lam_vld;

   always_comb begin
      state_d    = state_q;
      in_cnt_d   = in_cnt_q;
      out_cnt_d  = out_cnt_q;
      max_idx_d  = max_idx_q;
      max_val_d  = max_val_q;
      peak_idx_d = peak_idx_q;
      peak_val_d = peak_val_q;
      rho_d      = rho_q;

      accept  = in_valid && (state_q == RUN);
      lam_vld = vpipe_q[DP_LAT-1];
      vpipe_d = {vpipe_q[DP_LAT-2:0], accept};

      if (accept) begin
         in_cnt_d = in_cnt_q + IDX_W'(1);
      end

      // Strict compare: on ties the earliest index is kept.
      if (lam_vld) begin
         if ($signed(dp_lambda) > max_val_q) begin
            max_val_d = $signed(dp_lambda);
            max_idx_d = out_cnt_q;
         end
         out_cnt_d = out_cnt_q + IDX_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               rho_d     = rho_cfg;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               max_val_d = MIN_VAL;
               max_idx_d = '0;
            end
         end
         RUN: begin
            if (accept && (in_cnt_q == LAST_IDX)) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (lam_vld && (out_cnt_q == LAST_IDX)) begin
               state_d    = DONE;
               peak_idx_d = max_idx_d;
               peak_val_d = max_val_d;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         max_idx_q  <= '0;
         max_val_q  <= '0;
         peak_idx_q <= '0;
         peak_val_q <= '0;
         rho_q      <= '0;
         vpipe_q    <= '0;
      end else begin
         state_q    <= state_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         max_idx_q  <= max_idx_d;
         max_val_q  <= max_val_d;
         peak_idx_q <= peak_idx_d;
         peak_val_q <= peak_val_d;
         rho_q      <= rho_d;
         vpipe_q    <= vpipe_d;
      end
   end

   assign in_ready   = (state_q == RUN);
   assign busy       = (state_q != IDLE);
   assign peak_valid = (state_q == DONE);
   assign peak_idx   = peak_idx_q;
   assign peak_val   = peak_val_q;
   assign dp_mag     = in_mag;
   assign dp_phi     = in_phi;
   assign dp_rho     = rho_q;

endmodule

// File: tb/tb_lambda_peak_ctrl.sv
// Bench for lambda_peak_ctrl with WIN_LEN=8 and a behavioural 5-stage lambda datapath.
// Expected peaks come from an argmax over the accepted samples of each window.
module tb_lambda_peak_ctrl;

   localparam int WIN_LEN = 8;
   localparam int DP_LAT  = 5;
   localparam int IDX_W   = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [7:0]       rho_cfg;
   logic             in_valid;
   logic             in_ready;
   logic [13:0]      in_mag;
   logic [13:0]      in_phi;
   logic [13:0]      dp_mag;
   logic [13:0]      dp_phi;
   logic [7:0]       dp_rho;
   logic [13:0]      dp_lambda;
   logic             busy;
   logic             peak_valid;
   logic [IDX_W-1:0] peak_idx;
   logic [13:0]      peak_val;

   lambda_peak_ctrl #(.WIN_LEN(WIN_LEN), .DP_LAT(DP_LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .rho_cfg    (rho_cfg),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mag     (in_mag),
      .in_phi     (in_phi),
      .dp_mag     (dp_mag),
      .dp_phi     (dp_phi),
      .dp_rho     (dp_rho),
      .dp_lambda  (dp_lambda),
      .busy       (busy),
      .peak_valid (peak_valid),
      .peak_idx   (peak_idx),
      .peak_val   (peak_val)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;
   int peak_cnt = 0;
   int exp_pk_cnt = 0;

   logic [13:0] mag_a [WIN_LEN];
   logic [13:0] phi_a [WIN_LEN];
   int          gap_a [WIN_LEN];

   task automatic chk_eq(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // lambda = mag - rho*phi, Q6.8 result of Q1.7 x Q6.8, wrapped to 14 bits
   function automatic logic [13:0] lam_f(input logic [13:0] m, input logic [13:0] p, input logic [7:0] r);
      int mm, pp, rr, res;
      mm  = int'($signed(m));
      pp  = int'(p);
      rr  = int'($signed(r));
      res = mm - ((rr * pp) >>> 7);
      return res[13:0];
   endfunction

   logic [13:0] dpl [DP_LAT];
   always @(posedge clk) begin
      dpl[0] <= lam_f(dp_mag, dp_phi, dp_rho);
      for (int i = 1; i < DP_LAT; i++) dpl[i] <= dpl[i-1];
   end
   assign dp_lambda = dpl[DP_LAT-1];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (peak_valid) peak_cnt <= peak_cnt + 1;

   task automatic run_window(input logic [7:0] rho, input bit stray, input int exp_lat);
      int s, last, best, best_idx, v;
      bit got;
      best = -8192;
      best_idx = 0;
      for (int i = 0; i < WIN_LEN; i++) begin
         v = int'($signed(lam_f(mag_a[i], phi_a[i], rho)));
         if (v > best) begin
            best = v;
            best_idx = i;
         end
      end

      @(posedge clk); #1;
      start = 1'b1; rho_cfg = rho; s = cyc;
      @(negedge clk);
      chk_eq("idle_busy", int'(busy), 0);
      chk_eq("idle_pv", int'(peak_valid), 0);
      @(posedge clk); #1;
      start = 1'b0; rho_cfg = rho ^ 8'h5A;
      for (int i = 0; i < WIN_LEN; i++) begin
         in_valid = 1'b1; in_mag = mag_a[i]; in_phi = phi_a[i];
         if (stray && i == 2) begin
            start = 1'b1; rho_cfg = rho ^ 8'h33;
         end
         @(negedge clk);
         chk_eq("run_rdy", int'(in_ready), 1);
         if (i == 0) chk_eq("rho_latch", int'(dp_rho), int'(rho));
         last = cyc;
         @(posedge clk); #1;
         start = 1'b0; in_valid = 1'b0; in_mag = 14'($urandom); in_phi = 14'($urandom);
         repeat (gap_a[i]) begin
            @(posedge clk); #1;
         end
      end
      if (stray) begin
         start = 1'b1; rho_cfg = rho ^ 8'h77;
         @(negedge clk);
         chk_eq("flush_rdy", int'(in_ready), 0);
         chk_eq("flush_busy", int'(busy), 1);
         @(posedge clk); #1;
         start = 1'b0;
      end

      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (peak_valid) begin
            got = 1'b1;
            break;
         end
      end
      chk_eq("pv_seen", int'(got), 1);
      if (got) begin
         exp_pk_cnt++;
         chk_eq("pv_lat", cyc - last, DP_LAT + 1);
         chk_eq("peak_idx", int'(peak_idx), best_idx);
         chk_eq("peak_val", int'($signed(peak_val)), best);
         chk_eq("rho_hold", int'(dp_rho), int'(rho));
         if (exp_lat > 0) chk_eq("pv_from_start", cyc - s, exp_lat);
      end
   endtask

   task automatic set_ramp();
      for (int i = 0; i < WIN_LEN; i++) begin
         mag_a[i] = 14'((i + 1) * 10);
         phi_a[i] = 14'd0;
         gap_a[i] = 0;
      end
   endtask

   initial begin
      bit pv_any;
      logic [7:0] r;
      rst = 1'b1; start = 1'b0; rho_cfg = 8'd0; in_valid = 1'b0; in_mag = '0; in_phi = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_eq("rst_busy", int'(busy), 0);
      chk_eq("rst_rdy", int'(in_ready), 0);
      chk_eq("rst_pv", int'(peak_valid), 0);
      chk_eq("rst_idx", int'(peak_idx), 0);
      chk_eq("rst_val", int'(peak_val), 0);
      chk_eq("rst_rho", int'(dp_rho), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // ramp
      set_ramp();
      run_window(8'd0, 1'b0, 14);
      chk_eq("ramp_idx", int'(peak_idx), 7);
      chk_eq("ramp_val", int'($signed(peak_val)), 80);

      // rho scaling
      for (int i = 0; i < WIN_LEN; i++) begin
         mag_a[i] = 14'd128; phi_a[i] = 14'd256; gap_a[i] = 0;
      end
      mag_a[3] = 14'd1000;
      run_window(8'd64, 1'b0, 14);
      chk_eq("scale_val", int'($signed(peak_val)), 872);

      // bubbles and ties
      set_ramp();
      mag_a[0] = 14'd5; mag_a[1] = 14'd9; mag_a[2] = 14'd9; mag_a[3] = 14'd1;
      for (int i = 4; i < WIN_LEN; i++) mag_a[i] = 14'd0;
      gap_a[1] = 3; gap_a[5] = 2;
      run_window(8'd0, 1'b0, 19);
      chk_eq("tie_idx", int'(peak_idx), 1);

      // all negative, wrapped datapath values
      for (int i = 0; i < WIN_LEN; i++) begin
         mag_a[i] = -14'sd100; phi_a[i] = 14'h3FFF; gap_a[i] = 0;
      end
      mag_a[6] = -14'sd50;
      run_window(8'd127, 1'b0, 14);
      chk_eq("neg_idx", int'(peak_idx), 6);

      // stray starts in RUN and FLUSH
      set_ramp();
      mag_a[4] = 14'd500;
      run_window(8'd20, 1'b1, 0);

      // reset mid-window
      @(posedge clk); #1;
      start = 1'b1; rho_cfg = 8'd50;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_mag = 14'd999; in_phi = 14'd0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_eq("mrst_busy", int'(busy), 0);
      chk_eq("mrst_rdy", int'(in_ready), 0);
      chk_eq("mrst_rho", int'(dp_rho), 0);
      pv_any = 1'b0;
      repeat (20) begin
         @(negedge clk);
         pv_any |= peak_valid;
      end
      chk_eq("mrst_no_pv", int'(pv_any), 0);
      set_ramp();
      run_window(8'd0, 1'b0, 14);

      // randomized windows, started back-to-back after DONE
      for (int n = 0; n < 24; n++) begin
         r = 8'($urandom);
         for (int i = 0; i < WIN_LEN; i++) begin
            if (n % 2 == 1) begin
               mag_a[i] = 14'($urandom_range(0, 3));
               phi_a[i] = 14'd0;
            end else begin
               mag_a[i] = 14'($urandom);
               phi_a[i] = 14'($urandom);
            end
            gap_a[i] = $urandom_range(0, 2);
         end
         run_window(r, 1'($urandom_range(0, 1)), 0);
      end

      repeat (3) @(negedge clk);
      chk_eq("pv_count", peak_cnt, exp_pk_cnt);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
